mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the core's single valid/ready memory bus between the instruction-fetch path (the icache miss port) and the load/store data port. Forwards the winning request to memory with zero added latency and locks the grant until memory completes the transfer. Routes the response back to the owner. Sits between the core/icache and the memory or SoC bus.

## Interface
- AW, 32, address width of all ports
- DW, 32, data width of all ports; DW/8 write-strobe bits
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- i_valid  in  1  instruction request (read only)
- i_ready  out  1  instruction transfer completes this cycle
- i_addr  in  AW  instruction address
- i_rdata  out  DW  instruction read data; valid when i_ready
- d_valid  in  1  data request
- d_ready  out  1  data transfer completes this cycle
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_wstrb  in  DW/8  byte strobes; 0 = load
- d_rdata  out  DW  load data; valid when d_ready
- mem_valid  out  1  request to memory
- mem_ready  in  1  memory completes transfer (may be combinational on mem_valid)
- mem_addr  out  AW  forwarded address
- mem_wdata  out  DW  forwarded store data
- mem_wstrb  out  DW/8  forwarded strobes; 0 for instruction port
- mem_rdata  in  DW  memory read data
- mem_owner  out  1  current owner: 0 = instruction, 1 = data (debug)

## Operation
- States: IDLE, BUSY_I, BUSY_D. Register: last (last completed owner, reset 0).
- IDLE: arbitrate combinationally among requests asserted this cycle; forward winner's addr/wdata/wstrb and assert mem_valid in the same cycle.
  - If mem_ready in that cycle: winner's ready = 1; stay IDLE; last <= winner.
  - Else: go to BUSY_I / BUSY_D.
- BUSY_x: mux locked to owner x regardless of the other request; mem_valid = x_valid.
  - mem_ready with x_valid: x_ready = 1, last <= x, next IDLE.
  - x_valid dropped (protocol violation): mem_valid = 0, next IDLE, no ready issued.
- Winner selection when both request in IDLE: data port wins (default; see Configuration).
- rdata: i_rdata and d_rdata both wired to mem_rdata; only the owner's ready asserts. Never assert both readies in one cycle.
- Requesters hold valid/addr/wdata/wstrb stable until their ready; the arbiter relies on this.
- Idle mux selection (no request): instruction port; mem_valid = 0; mem_owner = 0.

## Timing
- Reset: state IDLE, last 0. While rstn low: mem_valid, i_ready, d_ready = 0; mem_owner = 0.
- Latency: zero cycles request-to-mem_valid; mem_ready to x_ready is purely combinational.
- Back-to-back: a completing transfer and the next arbitration happen in the same IDLE cycle sequence; with mem_ready tied high each requester can complete one transfer per cycle.
- Loser waits with ready = 0; its request is forwarded on the first IDLE cycle in which it wins.
- Reset mid-transaction: state returns IDLE, outstanding transfer abandoned without ready; memory must tolerate the dropped mem_valid.
- Simultaneous completion of owner and new request from other port: other port is arbitrated the following cycle (IDLE).

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, grant the port that is not `last`; single requests always granted.
- Not defined: fixed priority, data port always wins; `last` is still maintained but unused.

## Test plan
- Single instruction read, mem_ready high same cycle, mem_rdata=0x00000013 -> i_ready=1 same cycle, i_rdata=0x00000013, mem_wstrb=0, mem_owner=0.
- Data store d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=0xF, mem_ready delayed 3 cycles -> mem_valid held 4 cycles with stable fields, d_ready=1 only in 4th cycle, state BUSY_D for 3 cycles.
- Both request, mem_ready after 2 cycles each -> fixed priority: data completes first, instruction second; with ARB_ROUND_ROBIN_EN and last=1: instruction first.
- Instruction owns BUSY_I, data asserts mid-transfer -> mux stays on i_addr until i_ready; data issued next cycle.
- Assert rstn=0 during BUSY_D -> next cycle mem_valid=0, d_ready=0, state IDLE; fresh request after reset completes normally.
- Owner drops valid in BUSY_I -> mem_valid=0 that cycle, no i_ready, state IDLE next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : mem_arbiter
// Description : Two-port arbiter sharing a single valid/ready memory bus
//               between the instruction-fetch (icache miss) port and the
//               load/store data port. The winning request is forwarded with
//               zero added latency and the grant is held until memory
//               completes the transfer.
// Macro       : ARB_ROUND_ROBIN_EN - when defined, simultaneous requests in
//               IDLE go to the port that did not complete last; otherwise
//               the data port always wins.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rstn,
  // instruction port (read only)
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  // data port
  input  logic            d_valid,
  output logic            d_ready,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic [DW-1:0]   d_rdata,
  // memory side
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata,
  output logic            mem_owner
);

  localparam int SW = DW / 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;

  // Combinational grant/handshake results before reset gating
  logic       sel;        // 0 = instruction, 1 = data
  logic       mv;
  logic       i_rdy;
  logic       d_rdy;
  logic       both_win;   // winner when both ports request in IDLE

`ifdef ARB_ROUND_ROBIN_EN
  assign both_win = ~last_q;
`else
  assign both_win = 1'b1;
`endif

  // Next-state, grant selection and handshake generation
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel     = 1'b0;
    mv      = 1'b0;
    i_rdy   = 1'b0;
    d_rdy   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel = (i_valid && d_valid) ? both_win : d_valid;
        mv  = i_valid | d_valid;
        if (mv) begin
          if (mem_ready) begin
            // Completes in the arbitration cycle itself; stay in IDLE
            i_rdy  = ~sel;
            d_rdy  = sel;
            last_d = sel;
          end else begin
            state_d = sel ? ST_BUSY_D : ST_BUSY_I;
          end
        end
      end
      ST_BUSY_I: begin
        sel = 1'b0;
        mv  = i_valid;
        if (!i_valid) begin
          // Owner withdrew: abandon without a ready
          state_d = ST_IDLE;
        end else if (mem_ready) begin
          i_rdy   = 1'b1;
          last_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_BUSY_D: begin
        sel = 1'b1;
        mv  = d_valid;
        if (!d_valid) begin
          state_d = ST_IDLE;
        end else if (mem_ready) begin
          d_rdy   = 1'b1;
          last_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and last-owner registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Handshakes are forced low while reset is held so memory sees no request
  assign mem_valid = rstn & mv;
  assign i_ready   = rstn & i_rdy;
  assign d_ready   = rstn & d_rdy;
  assign mem_owner = rstn & sel;

  // Forwarding mux follows the owner; instruction fetches never write
  assign mem_addr  = mem_owner ? d_addr  : i_addr;
  assign mem_wdata = mem_owner ? d_wdata : {DW{1'b0}};
  assign mem_wstrb = mem_owner ? d_wstrb : {SW{1'b0}};

  // Read data is shared; only the owner's ready qualifies it
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  logic          clk;
  logic          rstn;
  logic          i_valid;
  logic          i_ready;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_valid;
  logic          d_ready;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_wstrb;
  logic [DW-1:0] d_rdata;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [DW-1:0] mem_rdata;
  logic          mem_owner;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_rdata   (d_rdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_owner (mem_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_valid = 1'b1; d_valid = 1'b1; mem_ready = 1'b1;
    i_addr = 32'h10; d_addr = 32'h20;
    tick(); tick();
    #1;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL reset_i_ready got=%b exp=0", i_ready); end
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL reset_d_ready got=%b exp=0", d_ready); end
    checks++; if (mem_owner !== 1'b0) begin errors++; $display("FAIL reset_owner got=%b exp=0", mem_owner); end
    i_valid = 1'b0; d_valid = 1'b0; mem_ready = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_ifetch();
    i_valid = 1'b1; i_addr = 32'h0000_0040; mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
    #1;
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL if_mem_valid got=%b exp=1", mem_valid); end
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL if_i_ready got=%b exp=1", i_ready); end
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL if_d_ready got=%b exp=0", d_ready); end
    checks++; if (i_rdata !== 32'h0000_0013) begin errors++; $display("FAIL if_rdata got=%h exp=00000013", i_rdata); end
    checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("FAIL if_wstrb got=%h exp=0", mem_wstrb); end
    checks++; if (mem_owner !== 1'b0) begin errors++; $display("FAIL if_owner got=%b exp=0", mem_owner); end
    checks++; if (mem_addr !== 32'h0000_0040) begin errors++; $display("FAIL if_addr got=%h exp=00000040", mem_addr); end
    tick();
    i_valid = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_store_wait();
    d_valid = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF; mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c == 3);
      // Instruction request arrives while data owns the bus; must be ignored
      i_valid = (c >= 1);
      i_addr  = 32'h0000_0200;
      #1;
      checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL st_mem_valid c=%0d got=%b exp=1", c, mem_valid); end
      checks++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'hF)
        begin errors++; $display("FAIL st_fields c=%0d got=%h/%h/%h exp=00000100/deadbeef/f", c, mem_addr, mem_wdata, mem_wstrb); end
      checks++; if (mem_owner !== 1'b1) begin errors++; $display("FAIL st_owner c=%0d got=%b exp=1", c, mem_owner); end
      checks++; if (d_ready !== (c == 3)) begin errors++; $display("FAIL st_d_ready c=%0d got=%b exp=%b", c, d_ready, (c == 3)); end
      checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL st_i_ready c=%0d got=%b exp=0", c, i_ready); end
      tick();
    end
    d_valid = 1'b0; i_valid = 1'b0; mem_ready = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL st_after got=%b exp=0", mem_valid); end
    tick();
  endtask

  // Both ports request; each transfer takes two cycles
  task automatic test_both();
    logic first;
    // last = 1 here (data completed most recently)
    first = RR ? 1'b0 : 1'b1;
    i_valid = 1'b1; i_addr = 32'h0000_0300;
    d_valid = 1'b1; d_addr = 32'h0000_0400; d_wdata = 32'h1111_2222; d_wstrb = 4'h3;
    for (int t = 0; t < 2; t++) begin
      logic own;
      own = (t == 0) ? first : ~first;
      for (int c = 0; c < 2; c++) begin
        mem_ready = (c == 1);
        #1;
        checks++; if (mem_owner !== own) begin errors++; $display("FAIL both_owner t=%0d c=%0d got=%b exp=%b", t, c, mem_owner, own); end
        checks++; if (mem_addr !== (own ? 32'h0000_0400 : 32'h0000_0300))
          begin errors++; $display("FAIL both_addr t=%0d c=%0d got=%h", t, c, mem_addr); end
        checks++; if (d_ready !== (own && c == 1) || i_ready !== (!own && c == 1))
          begin errors++; $display("FAIL both_ready t=%0d c=%0d got i=%b d=%b", t, c, i_ready, d_ready); end
        tick();
      end
      if (own) d_valid = 1'b0; else i_valid = 1'b0;
      mem_ready = 1'b0;
    end
    tick();
  endtask

  // Data request appears while instruction owns the bus
  task automatic test_lock();
    i_valid = 1'b1; i_addr = 32'h0000_0500; mem_ready = 1'b0;
    #1; tick();
    d_valid = 1'b1; d_addr = 32'h0000_0600; d_wstrb = 4'h0;
    #1;
    checks++; if (mem_owner !== 1'b0 || mem_addr !== 32'h0000_0500)
      begin errors++; $display("FAIL lock_hold got owner=%b addr=%h exp 0/00000500", mem_owner, mem_addr); end
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL lock_d_ready got=%b exp=0", d_ready); end
    tick();
    mem_ready = 1'b1;
    #1;
    checks++; if (i_ready !== 1'b1 || d_ready !== 1'b0)
      begin errors++; $display("FAIL lock_done got i=%b d=%b exp i=1 d=0", i_ready, d_ready); end
    checks++; if (mem_addr !== 32'h0000_0500) begin errors++; $display("FAIL lock_addr got=%h exp=00000500", mem_addr); end
    tick();
    i_valid = 1'b0;
    #1;
    checks++; if (mem_owner !== 1'b1 || d_ready !== 1'b1 || mem_addr !== 32'h0000_0600)
      begin errors++; $display("FAIL lock_next got owner=%b d=%b addr=%h exp 1/1/00000600", mem_owner, d_ready, mem_addr); end
    tick();
    d_valid = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    d_valid = 1'b1; d_addr = 32'h0000_0700; d_wstrb = 4'hF; mem_ready = 1'b0;
    tick();                      // now in BUSY_D
    rstn = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0 || d_ready !== 1'b0)
      begin errors++; $display("FAIL rstmid got mem_valid=%b d_ready=%b exp 0/0", mem_valid, d_ready); end
    tick();
    d_valid = 1'b0; rstn = 1'b1;
    // Only the instruction port requests; completes only if state left BUSY_D
    i_valid = 1'b1; i_addr = 32'h0000_0800; mem_ready = 1'b1;
    #1;
    checks++; if (i_ready !== 1'b1 || mem_valid !== 1'b1)
      begin errors++; $display("FAIL rstmid_fresh got i_ready=%b mem_valid=%b exp 1/1", i_ready, mem_valid); end
    tick();
    i_valid = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    i_valid = 1'b1; i_addr = 32'h0000_0900; mem_ready = 1'b0;
    tick();                      // now in BUSY_I
    i_valid = 1'b0; mem_ready = 1'b1;
    #1;
    checks++; if (mem_valid !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0)
      begin errors++; $display("FAIL drop got mv=%b i=%b d=%b exp 0/0/0", mem_valid, i_ready, d_ready); end
    tick();
    d_valid = 1'b1; d_addr = 32'h0000_0A00;
    #1;
    checks++; if (d_ready !== 1'b1 || mem_owner !== 1'b1)
      begin errors++; $display("FAIL drop_idle got d_ready=%b owner=%b exp 1/1", d_ready, mem_owner); end
    tick();
    d_valid = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_addr = 32'h0000_1000 + 32'(k * 4);
      mem_rdata = 32'hA000_0000 + 32'(k);
      #1;
      checks++; if (i_ready !== 1'b1 || mem_addr !== 32'h0000_1000 + 32'(k * 4) || i_rdata !== 32'hA000_0000 + 32'(k))
        begin errors++; $display("FAIL b2b k=%0d got ready=%b addr=%h rdata=%h", k, i_ready, mem_addr, i_rdata); end
      tick();
    end
    i_valid = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    rstn = 1'b0; i_valid = 1'b0; d_valid = 1'b0; mem_ready = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_rdata = '0;
    test_reset();
    test_ifetch();
    test_store_wait();
    test_both();
    test_lock();
    test_reset_mid();
    test_drop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
